// File: rtl/load_memory_responder.sv
// Responder end of the load channel: turns one load request at a time into a
// memory read transaction and returns the aligned word, with flush and timeout.
module load_memory_responder #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ldu_request_i,
    input  logic [DATA_WIDTH-1:0] ldu_address_i,
    output logic [DATA_WIDTH-1:0] ldu_data_o,
    output logic                  ldu_valid_o,
    output logic                  ldu_error_o,
    input  logic                  flush_i,
    output logic                  mem_request_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_error_i,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_d, data_d;
    logic                  valid_d, error_d;
    logic                  timeout_c;

    // Counter keeps running after acceptance, so compare with >= rather than ==.
    assign timeout_c = (cnt_q >= CNT_LAST);

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        addr_d  = mem_address_o;
        data_d  = '0;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ldu_request_i && !flush_i) begin
                    addr_d  = ldu_address_i & ALIGN_MASK;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (flush_i) begin
                    state_d = mem_ready_i ? S_DRAIN : S_IDLE;
                end else if (mem_ready_i) begin
                    state_d = S_WAIT;
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = mem_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_valid_i) begin
                    if (mem_error_i) begin
                        error_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = mem_data_i;
                    end
                    state_d = S_IDLE;
                end else if (timeout_c) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Flushed load: swallow the response or give up silently.
                if (mem_valid_i || timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mem_request_o <= 1'b0;
            mem_address_o <= '0;
            ldu_data_o    <= '0;
            ldu_valid_o   <= 1'b0;
            ldu_error_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_request_o <= (state_d == S_ISSUE);
            mem_address_o <= addr_d;
            ldu_data_o    <= data_d;
            ldu_valid_o   <= valid_d;
            ldu_error_o   <= error_d;
            busy_o        <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_load_memory_responder.sv
// Scoreboard bench for load_memory_responder: stimulus queues expected
// completions, a negedge monitor checks every valid/error pulse against them.
module tb_load_memory_responder;

    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          ldu_request_i;
    logic [DW-1:0] ldu_address_i;
    logic [DW-1:0] ldu_data_o;
    logic          ldu_valid_o;
    logic          ldu_error_o;
    logic          flush_i;
    logic          mem_request_o;
    logic [DW-1:0] mem_address_o;
    logic          mem_ready_i;
    logic          mem_valid_i;
    logic [DW-1:0] mem_data_i;
    logic          mem_error_i;
    logic          busy_o;

    load_memory_responder #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .ldu_request_i(ldu_request_i),
        .ldu_address_i(ldu_address_i),
        .ldu_data_o   (ldu_data_o),
        .ldu_valid_o  (ldu_valid_o),
        .ldu_error_o  (ldu_error_o),
        .flush_i      (flush_i),
        .mem_request_o(mem_request_o),
        .mem_address_o(mem_address_o),
        .mem_ready_i  (mem_ready_i),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i),
        .mem_error_i  (mem_error_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_resp(input logic err, input logic [DW-1:0] data, input int at);
        exp_t e;
        e.err  = err;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Issue a request and run it through acceptance into WAIT.
    task automatic start_load(input logic [DW-1:0] addr, input logic [DW-1:0] exp_addr, input string name);
        ldu_request_i = 1'b1;
        ldu_address_i = addr;
        tick();
        ldu_request_i = 1'b0;
        check({name, "_req"}, DW'(mem_request_o), DW'(1));
        check({name, "_addr"}, mem_address_o, exp_addr);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        check({name, "_req_drop"}, DW'(mem_request_o), DW'(0));
    endtask

    task automatic respond(input logic err, input logic [DW-1:0] data, input logic expect_it);
        mem_valid_i = 1'b1;
        mem_error_i = err;
        mem_data_i  = data;
        if (expect_it) expect_resp(err, err ? '0 : data, cyc + 1);
        tick();
        mem_valid_i = 1'b0;
        mem_error_i = 1'b0;
        mem_data_i  = '0;
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && (ldu_valid_o || ldu_error_o)) begin
            checks++;
            if (ldu_valid_o && ldu_error_o) begin
                errors++;
                $display("FAIL resp_excl: valid and error both high at cycle %0d", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: valid=%0b error=%0b data=0x%08h at cycle %0d, none expected",
                         ldu_valid_o, ldu_error_o, ldu_data_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ldu_error_o !== e.err || ldu_data_o !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp: got err=%0b data=0x%08h cycle=%0d expected err=%0b data=0x%08h cycle=%0d",
                             ldu_error_o, ldu_data_o, cyc, e.err, e.data, e.cyc);
                end
            end
        end else if (rst_n_i === 1'b1 && busy_o === 1'b0 && cyc > 2) begin
            checks++;
            if (ldu_data_o !== '0) begin
                errors++;
                $display("FAIL idle_data: got 0x%08h expected 0x00000000", ldu_data_o);
            end
        end
    end

    // The load unit never requests while the responder is busy.
    always @(posedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            assert (!(ldu_request_i && busy_o))
            else begin
                errors++;
                $display("FAIL req_while_busy at cycle %0d", cyc);
            end
        end
    end

    initial begin
        int c0;
        rst_n_i       = 1'b0;
        ldu_request_i = 1'b0;
        ldu_address_i = '0;
        flush_i       = 1'b0;
        mem_ready_i   = 1'b0;
        mem_valid_i   = 1'b0;
        mem_data_i    = '0;
        mem_error_i   = 1'b0;
        tick();
        tick();
        check("rst_busy", DW'(busy_o), DW'(0));
        check("rst_req", DW'(mem_request_o), DW'(0));
        check("rst_addr", mem_address_o, '0);
        check("rst_valid", DW'(ldu_valid_o), DW'(0));
        check("rst_error", DW'(ldu_error_o), DW'(0));
        check("rst_data", ldu_data_o, '0);
        rst_n_i = 1'b1;
        tick();

        // Basic load, then back-to-back request in the valid cycle
        start_load(32'h0000_1006, 32'h0000_1004, "basic");
        tick();
        respond(1'b0, 32'hDEAD_BEEF, 1'b1);
        check("basic_busy_after", DW'(busy_o), DW'(0));
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_300B;
        tick();
        ldu_request_i = 1'b0;

        // Backpressure: ready low 5 cycles, request stays high 6 cycles
        for (int i = 0; i < 5; i++) begin
            check("bp_req", DW'(mem_request_o), DW'(1));
            check("bp_addr", mem_address_o, 32'h0000_3008);
            tick();
        end
        mem_ready_i = 1'b1;
        check("bp_req6", DW'(mem_request_o), DW'(1));
        tick();
        mem_ready_i = 1'b0;
        check("bp_req_drop", DW'(mem_request_o), DW'(0));
        respond(1'b0, 32'h1234_5678, 1'b1);
        tick();

        // Bus error
        start_load(32'h0000_0041, 32'h0000_0040, "berr");
        respond(1'b1, 32'hFFFF_FFFF, 1'b1);
        check("berr_busy_after", DW'(busy_o), DW'(0));
        tick();

        // Timeout: error pulse 8 cycles after entering ISSUE
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_0080;
        tick();
        ldu_request_i = 1'b0;
        c0 = cyc;
        expect_resp(1'b1, '0, c0 + 8);
        repeat (7) tick();
        check("to_req_before", DW'(mem_request_o), DW'(1));
        tick();
        check("to_req_after", DW'(mem_request_o), DW'(0));
        check("to_busy_after", DW'(busy_o), DW'(0));
        tick();

        // Flush in WAIT, response 3 cycles later is discarded
        start_load(32'h0000_0100, 32'h0000_0100, "flw");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flw_busy1", DW'(busy_o), DW'(1));
        tick();
        check("flw_busy2", DW'(busy_o), DW'(1));
        tick();
        check("flw_busy3", DW'(busy_o), DW'(1));
        respond(1'b0, 32'h0000_0BAD, 1'b0);
        check("flw_busy_after", DW'(busy_o), DW'(0));
        start_load(32'h0000_0204, 32'h0000_0204, "flw_next");
        respond(1'b0, 32'hCAFE_F00D, 1'b1);
        tick();

        // Flush beats a request in IDLE; flush in ISSUE returns to IDLE
        flush_i       = 1'b1;
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_0300;
        tick();
        flush_i       = 1'b0;
        ldu_request_i = 1'b0;
        check("fli_busy", DW'(busy_o), DW'(0));
        check("fli_req", DW'(mem_request_o), DW'(0));
        ldu_request_i = 1'b1;
        tick();
        ldu_request_i = 1'b0;
        flush_i       = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fls_req", DW'(mem_request_o), DW'(0));
        check("fls_busy", DW'(busy_o), DW'(0));
        tick();

        // Reset mid-WAIT, then a late response is ignored
        start_load(32'h0000_0500, 32'h0000_0500, "rw");
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("rw_busy", DW'(busy_o), DW'(0));
        check("rw_req", DW'(mem_request_o), DW'(0));
        check("rw_addr", mem_address_o, '0);
        respond(1'b0, 32'h5555_5555, 1'b0);
        check("rw_late_busy", DW'(busy_o), DW'(0));
        start_load(32'h0000_2000, 32'h0000_2000, "rw_next");
        respond(1'b0, 32'h1357_9BDF, 1'b1);
        repeat (4) tick();

        check("sb_empty", DW'(sb.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
